sec_graph_loader: RTL and testbench
===================================

# sec_graph_loader

Write-side counterpart of the security monitor: programs the monitoring graph into the basic-block RAM (both copies) and the next-hop RAM, which the monitor pipeline only reads. Accepts a load command plus a word stream of (basic-block, next-hop) pairs, or a clear command. Drives the shared RAM write port. Holds the monitor off while the graph is inconsistent.

## Interface
- ADDR_W, 11, graph index width (byte address bits [12:2])
- DATA_W, 32, entry width
- ENTRIES, 2048, graph depth (2**ADDR_W)
- core_sp_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- clear_start  in  1  pulse: zero-fill all ENTRIES
- load_start  in  1  pulse: begin load of load_count pairs at load_base
- load_base  in  ADDR_W  first entry index, sampled on load_start
- load_count  in  ADDR_W+1  number of pairs, legal 1..ENTRIES, sampled on load_start
- wr_data  in  DATA_W  stream word
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  loader accepts wr_data this cycle
- mem_addr  out  ADDR_W  shared address to bb_ram, duplicate bb_ram, next_hop_ram
- bb_data  out  DATA_W  write data to both bb_ram copies
- nh_data  out  DATA_W  write data to next_hop_ram
- mem_we  out  4  byte write enables, all three RAMs (4'b1111 or 4'b0000)
- monitor_hold  out  1  monitor must suppress drop_packet and flush its FIFOs
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle pulse on rejected command

## Operation
- States: IDLE, CLEAR, GET_BB, GET_NH, DONE.
- IDLE: clear_start -> CLEAR, index=0. Else load_start with 1<=load_count<=ENTRIES -> GET_BB, index=load_base, remaining=load_count. load_count of 0 or >ENTRIES -> err pulse, stay IDLE.
- clear_start and load_start in the same cycle: clear wins, load dropped, no err.
- Either start while busy: ignored, no err.
- CLEAR: one write per cycle, data 0, index 0..ENTRIES-1; after index ENTRIES-1 written -> DONE.
- GET_BB: wr_ready=1; on wr_valid store word in bb holding reg -> GET_NH.
- GET_NH: wr_ready=1; on wr_valid issue write of {held bb, wr_data} at index, index+1 mod ENTRIES, remaining-1; remaining reaches 0 -> DONE, else -> GET_BB.
- Index wraps 2047 -> 0 silently; load_base+load_count > ENTRIES is legal and wraps.
- DONE: done=1 for one cycle -> IDLE.
- Writes to both bb_ram copies always identical (same addr, data, enable).

## Timing
- All outputs registered. Reset values: wr_ready 0, mem_addr 0, bb_data 0, nh_data 0, mem_we 0, monitor_hold 0, busy 0, done 0, err 0.
- Write latency: mem_we=4'b1111 with addr/data the cycle after the accepting GET_NH beat (CLEAR: the cycle after the state cycle); mem_we=0 otherwise.
- wr_ready is a registered function of next state; no combinational path from wr_valid.
- Full-rate load: one pair per 2 cycles when wr_valid held high; wr_valid gaps stall without loss.
- CLEAR: ENTRIES+2 cycles start to done.
- monitor_hold asserts the cycle after an accepted start, deasserts the cycle after done, covering the final write.
- err pulse the cycle after the rejected load_start.
- reset mid-operation: next cycle IDLE, all outputs at reset values, no further writes; entries already written stay written, held bb word discarded.

## Structure
- Shared header sec_monitor_defs.vh: ADDR_W/ENTRIES/DATA_W constants, state encodings, WE_ALL=4'b1111; sec_monitor reuses the index width.
- Single flat module; no sub-module. Top-level muxes its write port onto the currently tied-off RAM data_in/we pins.

## Test plan
- Reset then load_start base=5 count=3, six words A0,N0,A1,N1,A2,N2 back-to-back -> writes at 5,6,7 with matching pairs, done 1 cycle after last write, monitor_hold low after.
- load base=2046 count=3 -> writes at 2046, 2047, 0; no err.
- clear_start -> 2048 writes of 0 at addresses 0..2047 in order, done at cycle 2050, wr_ready never high.
- load_start count=0, then count=2049 -> err pulse each, no writes, busy stays 0.
- load count=2 with wr_valid toggled every other cycle, plus load_start/clear_start mid-load -> both pairs written correctly, extra starts ignored.
- Reset asserted after first bb word of a load -> no write issued, all outputs reset next cycle, new load afterward behaves normally.

Source files
------------

// File: rtl/sec_graph_loader_pkg.sv
// Shared types and constants for the monitoring-graph loader: index/data widths,
// FSM state encoding and the registered RAM write-port payload.
package sec_graph_loader_pkg;

  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ENTRIES = 2 ** ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned WE_W    = 4;

  localparam logic [WE_W-1:0]   WE_ALL     = 4'b1111;
  localparam logic [WE_W-1:0]   WE_NONE    = 4'b0000;
  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(ENTRIES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GET_BB = 3'd2,
    ST_GET_NH = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // One write beat on the shared port; both bb_ram copies see the same bb field.
  typedef struct packed {
    logic [WE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] bb;
    logic [DATA_W-1:0] nh;
  } mem_wr_t;

  // A load must cover at least one pair and at most the whole graph.
  function automatic logic count_legal(input logic [CNT_W-1:0] cnt);
    return (cnt != CNT_W'(0)) && (cnt <= CNT_W'(ENTRIES));
  endfunction

endpackage

// File: rtl/sec_graph_loader_if.sv
// Command, word-stream and RAM write-port bundle between the host side and the
// graph loader.
interface sec_graph_loader_if;
  import sec_graph_loader_pkg::*;

  logic                clear_start;
  logic                load_start;
  logic [ADDR_W-1:0]   load_base;
  logic [CNT_W-1:0]    load_count;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   bb_data;
  logic [DATA_W-1:0]   nh_data;
  logic [WE_W-1:0]     mem_we;
  logic                monitor_hold;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output clear_start, load_start, load_base, load_count, wr_data, wr_valid,
    input  wr_ready, mem_addr, bb_data, nh_data, mem_we, monitor_hold, busy, done, err
  );

  modport slave (
    input  clear_start, load_start, load_base, load_count, wr_data, wr_valid,
    output wr_ready, mem_addr, bb_data, nh_data, mem_we, monitor_hold, busy, done, err
  );

endinterface

// File: rtl/sec_graph_loader.sv
// Programs (basic-block, next-hop) pairs or a zero-fill into the monitor graph RAMs
// through one registered write port, holding the monitor off while the graph changes.
module sec_graph_loader
  import sec_graph_loader_pkg::*;
(
  input  logic                     core_sp_clk,
  input  logic                     reset,
  sec_graph_loader_if.slave        bus
);

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   index_q,     index_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [DATA_W-1:0]   bb_hold_q,   bb_hold_d;
  mem_wr_t             wr_q,        wr_d;
  logic                wr_ready_q,  wr_ready_d;
  logic                hold_q,      hold_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                err_q,       err_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    remaining_d = remaining_q;
    bb_hold_d   = bb_hold_q;
    wr_d        = wr_q;
    wr_d.we     = WE_NONE;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Clear has priority; a coincident load is dropped without complaint.
        if (bus.clear_start) begin
          state_d = ST_CLEAR;
          index_d = '0;
        end else if (bus.load_start) begin
          if (count_legal(bus.load_count)) begin
            state_d     = ST_GET_BB;
            index_d     = bus.load_base;
            remaining_d = bus.load_count;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        wr_d.we   = WE_ALL;
        wr_d.addr = index_q;
        wr_d.bb   = '0;
        wr_d.nh   = '0;
        index_d   = index_q + ADDR_W'(1);
        if (index_q == LAST_INDEX) begin
          state_d = ST_DONE;
        end
      end

      ST_GET_BB: begin
        if (bus.wr_valid && wr_ready_q) begin
          bb_hold_d = bus.wr_data;
          state_d   = ST_GET_NH;
        end
      end

      ST_GET_NH: begin
        if (bus.wr_valid && wr_ready_q) begin
          wr_d.we     = WE_ALL;
          wr_d.addr   = index_q;
          wr_d.bb     = bb_hold_q;
          wr_d.nh     = bus.wr_data;
          index_d     = index_q + ADDR_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_GET_BB;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wr_ready_d = (state_d == ST_GET_BB) || (state_d == ST_GET_NH);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_q == ST_DONE);
    // Stay held through the done pulse so the last write lands before release.
    hold_d     = busy_d || (state_q == ST_DONE);
  end

  always_ff @(posedge core_sp_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      remaining_q <= '0;
      bb_hold_q   <= '0;
      wr_q        <= '0;
      wr_ready_q  <= 1'b0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      remaining_q <= remaining_d;
      bb_hold_q   <= bb_hold_d;
      wr_q        <= wr_d;
      wr_ready_q  <= wr_ready_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.wr_ready     = wr_ready_q;
  assign bus.mem_addr     = wr_q.addr;
  assign bus.bb_data      = wr_q.bb;
  assign bus.nh_data      = wr_q.nh;
  assign bus.mem_we       = wr_q.we;
  assign bus.monitor_hold = hold_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_sec_graph_loader.sv
// Self-checking bench for sec_graph_loader: table of load commands plus hand-built
// clear, collision, mid-load-start and reset sequences, with a write scoreboard.
module tb_sec_graph_loader;
  import sec_graph_loader_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] bb;
    logic [DATA_W-1:0] nh;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  count;
    int                gap;
    bit                exp_err;
  } vec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  wr_t  exp_q[$];
  int   done_cnt, err_cnt, ready_cnt;
  int   done_cyc, err_cyc, last_wr_cyc;
  bit   prev_done, busy_seen;

  sec_graph_loader_if bus ();

  sec_graph_loader dut (
    .core_sp_clk (clk),
    .reset       (reset),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write-port scoreboard and pulse bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we != WE_NONE) begin
      check("mem_we", 96'(bus.mem_we), 96'(WE_ALL));
      check("hold_during_write", 96'(bus.monitor_hold), 96'(1));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h bb=%0h nh=%0h", bus.mem_addr, bus.bb_data, bus.nh_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_pair", 96'({bus.mem_addr, bus.bb_data, bus.nh_data}), 96'(e));
      end
      last_wr_cyc = cyc;
    end
    if (prev_done) check("hold_after_done", 96'(bus.monitor_hold), 96'(0));
    if (bus.done === 1'b1) begin
      check("hold_at_done", 96'(bus.monitor_hold), 96'(1));
      done_cnt++;
      done_cyc = cyc;
    end
    prev_done = (bus.done === 1'b1);
    if (bus.err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.busy === 1'b1) busy_seen = 1'b1;
    if (bus.wr_ready === 1'b1) ready_cnt++;
  end

  task automatic send_word(input logic [DATA_W-1:0] w, input int gap);
    bit acc;
    acc = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.wr_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.wr_ready;
      @(posedge clk); #1;
    end
    check("word_accepted", 96'(acc), 96'(1));
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int k = 0; k < budget && done_cnt == d0; k++) @(negedge clk);
    check("done_seen", 96'(done_cnt - d0), 96'(1));
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_ready", 96'(bus.wr_ready), 96'(0));
    check("rst_mem_addr", 96'(bus.mem_addr), 96'(0));
    check("rst_bb_data",  96'(bus.bb_data), 96'(0));
    check("rst_nh_data",  96'(bus.nh_data), 96'(0));
    check("rst_mem_we",   96'(bus.mem_we), 96'(0));
    check("rst_hold",     96'(bus.monitor_hold), 96'(0));
    check("rst_busy",     96'(bus.busy), 96'(0));
    check("rst_done",     96'(bus.done), 96'(0));
    check("rst_err",      96'(bus.err), 96'(0));
  endtask

  task automatic do_vec(input vec_t v);
    int e0, d0, s;
    wr_t e;
    logic [DATA_W-1:0] a, n;
    e0 = err_cnt;
    d0 = done_cnt;
    busy_seen = 1'b0;
    @(posedge clk); #1;
    s = cyc;
    bus.load_start = 1'b1;
    bus.load_base  = v.base;
    bus.load_count = v.count;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    if (v.exp_err) begin
      repeat (3) @(negedge clk);
      check("err_pulse", 96'(err_cnt - e0), 96'(1));
      check("err_latency", 96'(err_cyc - s), 96'(1));
      check("err_busy", 96'(busy_seen), 96'(0));
      check("err_no_done", 96'(done_cnt - d0), 96'(0));
    end else begin
      for (int i = 0; i < int'(v.count); i++) begin
        a = $urandom;
        n = $urandom;
        e.addr = ADDR_W'(int'(v.base) + i);
        e.bb   = a;
        e.nh   = n;
        exp_q.push_back(e);
        send_word(a, v.gap);
        send_word(n, v.gap);
      end
      bus.wr_valid = 1'b0;
      wait_done(d0, 20);
      check("done_after_last_write", 96'(done_cyc - last_wr_cyc), 96'(1));
      check("load_no_err", 96'(err_cnt - e0), 96'(0));
      check("load_drained", 96'(exp_q.size()), 96'(0));
      @(negedge clk);
    end
  endtask

  task automatic do_clear(input bit with_load);
    int d0, e0, s;
    wr_t e;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      e.addr = ADDR_W'(i);
      e.bb   = '0;
      e.nh   = '0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    ready_cnt = 0;
    s = cyc;
    bus.clear_start = 1'b1;
    bus.load_start  = with_load;
    bus.load_base   = ADDR_W'(9);
    bus.load_count  = CNT_W'(3);
    @(posedge clk); #1;
    bus.clear_start = 1'b0;
    bus.load_start  = 1'b0;
    wait_done(d0, 2100);
    check("clear_latency", 96'(done_cyc - s), 96'(ENTRIES + 2));
    check("clear_no_ready", 96'(ready_cnt), 96'(0));
    check("clear_no_err", 96'(err_cnt - e0), 96'(0));
    check("clear_drained", 96'(exp_q.size()), 96'(0));
    @(negedge clk);
  endtask

  vec_t vecs[8];

  initial begin
    int d0, e0;
    logic [DATA_W-1:0] w[4];
    wr_t e;

    checks = 0; errors = 0;
    done_cnt = 0; err_cnt = 0; ready_cnt = 0;
    done_cyc = 0; err_cyc = 0; last_wr_cyc = 0;
    prev_done = 1'b0; busy_seen = 1'b0;

    vecs[0] = '{base: 11'd5,    count: 12'd3,    gap: 0, exp_err: 1'b0};
    vecs[1] = '{base: 11'd2046, count: 12'd3,    gap: 0, exp_err: 1'b0};
    vecs[2] = '{base: 11'd0,    count: 12'd0,    gap: 0, exp_err: 1'b1};
    vecs[3] = '{base: 11'd0,    count: 12'd2049, gap: 0, exp_err: 1'b1};
    vecs[4] = '{base: 11'd100,  count: 12'd2,    gap: 1, exp_err: 1'b0};
    vecs[5] = '{base: 11'd2047, count: 12'd1,    gap: 2, exp_err: 1'b0};
    vecs[6] = '{base: 11'd10,   count: 12'd4095, gap: 0, exp_err: 1'b1};
    vecs[7] = '{base: 11'd1000, count: 12'd2048, gap: 0, exp_err: 1'b0};

    reset           = 1'b1;
    bus.clear_start = 1'b0;
    bus.load_start  = 1'b0;
    bus.load_base   = '0;
    bus.load_count  = '0;
    bus.wr_data     = '0;
    bus.wr_valid    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) do_vec(vecs[i]);

    do_clear(1'b0);
    do_clear(1'b1);

    // Stray starts during an active, gapped load must be ignored.
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    for (int i = 0; i < 2; i++) begin
      e.addr = ADDR_W'(300 + i);
      e.bb   = w[2*i];
      e.nh   = w[2*i+1];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.load_base  = ADDR_W'(300);
    bus.load_count = CNT_W'(2);
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_word(w[i], 1);
        bus.wr_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk); #1;
        bus.clear_start = 1'b1;
        bus.load_start  = 1'b1;
        bus.load_count  = CNT_W'(0);
        @(posedge clk); #1;
        bus.clear_start = 1'b0;
        bus.load_start  = 1'b0;
        repeat (2) @(posedge clk); #1;
        bus.load_start  = 1'b1;
        bus.load_count  = CNT_W'(5);
        @(posedge clk); #1;
        bus.load_start  = 1'b0;
      end
    join
    wait_done(d0, 20);
    check("midload_no_err", 96'(err_cnt - e0), 96'(0));
    check("midload_drained", 96'(exp_q.size()), 96'(0));
    repeat (10) @(negedge clk);
    check("midload_idle", 96'(bus.busy), 96'(0));
    check("midload_single_done", 96'(done_cnt - d0), 96'(1));

    // Reset after the first bb word: nothing may be written, outputs clear next cycle.
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.load_base  = ADDR_W'(50);
    bus.load_count = CNT_W'(3);
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    send_word(32'hDEAD_BEEF, 0);
    bus.wr_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_no_done", 96'(done_cnt - d0), 96'(0));
    check("reset_no_write", 96'(exp_q.size()), 96'(0));
    do_vec('{base: 11'd50, count: 12'd2, gap: 0, exp_err: 1'b0});

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
